id_stage: RTL and testbench

- Registered RV32I instruction decode stage; the producer side of the ALU interface.
- Accepts a fetched instruction and PC over a valid/ready handshake.
- Decodes the instruction into ALU opcode, operand-select controls, register addresses and sign-extended immediate.
- Presents the result one cycle later in a pipeline register toward execute, with stall (backpressure) and flush support.

---
 rtl/id_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// rtl/id_stage.sv - registered RV32I decode stage feeding execute over valid/ready
module id_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [3:0]            alu_op,
    output logic [1:0]            a_sel,
    output logic                  b_imm,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    output logic [4:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [2:0]            op_class,
    output logic [2:0]            funct3,
    output logic                  reg_write,
    output logic                  illegal
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JAL    = 3'd4;
    localparam logic [2:0] CLS_JALR   = 3'd5;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_sh = {27'b0, in_instr[24:20]};

    logic [3:0]  d_alu_op;
    logic [1:0]  d_a_sel;
    logic        d_b_imm;
    logic [31:0] d_imm;
    logic [2:0]  d_class;
    logic        d_wr;
    logic        d_illegal;

    always_comb begin
        d_alu_op  = ALU_ADD;
        d_a_sel   = A_RS1;
        d_b_imm   = 1'b0;
        d_imm     = 32'd0;
        d_class   = CLS_ALU;
        d_wr      = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            7'b0010011: begin
                d_b_imm = 1'b1;
                d_wr    = 1'b1;
                d_imm   = imm_i;
                case (f3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b010: d_alu_op = ALU_SLT;
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b110: d_alu_op = ALU_OR;
                    3'b111: d_alu_op = ALU_AND;
                    3'b001: begin
                        d_imm     = imm_sh;
                        d_alu_op  = ALU_SLL;
                        d_illegal = (f7 != F7_BASE);
                    end
                    default: begin
                        d_imm = imm_sh;
                        if (f7 == F7_BASE)     d_alu_op  = ALU_SRL;
                        else if (f7 == F7_ALT) d_alu_op  = ALU_SRA;
                        else                   d_illegal = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                d_wr = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  d_alu_op = ALU_ADD;
                        3'b001:  d_alu_op = ALU_SLL;
                        3'b010:  d_alu_op = ALU_SLT;
                        3'b011:  d_alu_op = ALU_SLTU;
                        3'b100:  d_alu_op = ALU_XOR;
                        3'b101:  d_alu_op = ALU_SRL;
                        3'b110:  d_alu_op = ALU_OR;
                        default: d_alu_op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    d_alu_op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    d_alu_op = ALU_SRA;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            7'b0110111: begin
                d_a_sel = A_ZERO;
                d_b_imm = 1'b1;
                d_imm   = imm_u;
                d_wr    = 1'b1;
            end
            7'b0010111: begin
                d_a_sel = A_PC;
                d_b_imm = 1'b1;
                d_imm   = imm_u;
                d_wr    = 1'b1;
            end
            7'b0000011: begin
                d_b_imm   = 1'b1;
                d_imm     = imm_i;
                d_class   = CLS_LOAD;
                d_wr      = 1'b1;
                d_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            7'b0100011: begin
                d_b_imm   = 1'b1;
                d_imm     = imm_s;
                d_class   = CLS_STORE;
                d_illegal = (f3 > 3'b010);
            end
            7'b1100011: begin
                d_imm   = imm_b;
                d_class = CLS_BRANCH;
                case (f3)
                    3'b000, 3'b001: d_alu_op  = ALU_SUB;
                    3'b100, 3'b101: d_alu_op  = ALU_SLT;
                    3'b110, 3'b111: d_alu_op  = ALU_SLTU;
                    default:        d_illegal = 1'b1;
                endcase
            end
            7'b1101111: begin
                d_a_sel = A_PC;
                d_b_imm = 1'b1;
                d_imm   = imm_j;
                d_class = CLS_JAL;
                d_wr    = 1'b1;
            end
            7'b1100111: begin
                d_b_imm   = 1'b1;
                d_imm     = imm_i;
                d_class   = CLS_JALR;
                d_wr      = 1'b1;
                d_illegal = (f3 != 3'b000);
            end
            default: d_illegal = 1'b1;
        endcase
        if (in_instr[11:7] == 5'd0) d_wr = 1'b0;
        // Illegal bundles still flow to execute so the trap is taken in order.
        if (d_illegal) begin
            d_wr     = 1'b0;
            d_alu_op = ALU_ADD;
            d_class  = CLS_ALU;
        end
    end

    logic load;

    assign in_ready = !ex_valid || ex_ready || flush;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            alu_op    <= ALU_ADD;
            a_sel     <= A_RS1;
            b_imm     <= 1'b0;
            rs1_addr  <= 5'd0;
            rs2_addr  <= 5'd0;
            rd_addr   <= 5'd0;
            imm       <= '0;
            op_class  <= CLS_ALU;
            funct3    <= 3'd0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (load) begin
            ex_valid  <= 1'b1;
            ex_pc     <= in_pc;
            alu_op    <= d_alu_op;
            a_sel     <= d_a_sel;
            b_imm     <= d_b_imm;
            rs1_addr  <= in_instr[19:15];
            rs2_addr  <= in_instr[24:20];
            rd_addr   <= in_instr[11:7];
            imm       <= d_imm;
            op_class  <= d_class;
            funct3    <= f3;
            reg_write <= d_wr;
            illegal   <= d_illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] imm;
    logic [2:0]  op_class;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    id_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .alu_op(alu_op), .a_sel(a_sel), .b_imm(b_imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .imm(imm), .op_class(op_class), .funct3(funct3),
        .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Presents one instruction for exactly one rising edge.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        in_instr = 32'd0; in_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
        total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL reset_alu_op got=%0d exp=0", alu_op); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b exp=0", illegal); end
        total++; if (imm !== 32'd0) begin bad++; $display("FAIL reset_imm got=%h exp=0", imm); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        idle();
        send(32'h00500093, 32'h100);
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL addi_ex_valid got=%0b exp=1", ex_valid); end
        total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL addi_alu_op got=%0d exp=0", alu_op); end
        total++; if (b_imm !== 1'b1) begin bad++; $display("FAIL addi_b_imm got=%0b exp=1", b_imm); end
        total++; if (imm !== 32'd5) begin bad++; $display("FAIL addi_imm got=%h exp=5", imm); end
        total++; if (rd_addr !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d exp=1", rd_addr); end
        total++; if (rs1_addr !== 5'd0) begin bad++; $display("FAIL addi_rs1 got=%0d exp=0", rs1_addr); end
        total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL addi_reg_write got=%0b exp=1", reg_write); end
        total++; if (op_class !== 3'd0) begin bad++; $display("FAIL addi_op_class got=%0d exp=0", op_class); end
        total++; if (ex_pc !== 32'h100) begin bad++; $display("FAIL addi_ex_pc got=%h exp=100", ex_pc); end
        @(posedge clk); #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%0b exp=0", ex_valid); end
    endtask

    task automatic test_back_to_back();
        idle();
        send(32'h402081B3, 32'h110);
        total++; if (alu_op !== 4'd1) begin bad++; $display("FAIL sub_alu_op got=%0d exp=1", alu_op); end
        total++; if (b_imm !== 1'b0) begin bad++; $display("FAIL sub_b_imm got=%0b exp=0", b_imm); end
        total++; if ({rs1_addr, rs2_addr, rd_addr} !== {5'd1, 5'd2, 5'd3}) begin bad++;
            $display("FAIL sub_regs got=%0d/%0d/%0d exp=1/2/3", rs1_addr, rs2_addr, rd_addr); end
        send(32'h40335293, 32'h114);
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL srai_ex_valid got=%0b exp=1", ex_valid); end
        total++; if (alu_op !== 4'd7) begin bad++; $display("FAIL srai_alu_op got=%0d exp=7", alu_op); end
        total++; if (imm !== 32'd3) begin bad++; $display("FAIL srai_imm got=%h exp=3", imm); end
        total++; if (ex_pc !== 32'h114) begin bad++; $display("FAIL srai_ex_pc got=%h exp=114", ex_pc); end
    endtask

    task automatic test_lui_illegal();
        idle();
        send(32'h123453B7, 32'h120);
        total++; if (a_sel !== 2'd2) begin bad++; $display("FAIL lui_a_sel got=%0d exp=2", a_sel); end
        total++; if (imm !== 32'h12345000) begin bad++; $display("FAIL lui_imm got=%h exp=12345000", imm); end
        total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL lui_alu_op got=%0d exp=0", alu_op); end
        total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL lui_reg_write got=%0b exp=1", reg_write); end
        send(32'h02000033, 32'h124);
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_illegal got=%0b exp=1", illegal); end
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL ill_reg_write got=%0b exp=0", reg_write); end
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL ill_ex_valid got=%0b exp=1", ex_valid); end
        total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL ill_alu_op got=%0d exp=0", alu_op); end
    endtask

    task automatic test_formats();
        idle();
        send(32'h00208463, 32'h130);
        total++; if ({op_class, alu_op, b_imm, reg_write} !== {3'd3, 4'd1, 1'b0, 1'b0}) begin bad++;
            $display("FAIL beq_ctrl got=%0d/%0d/%0b/%0b exp=3/1/0/0", op_class, alu_op, b_imm, reg_write); end
        total++; if (imm !== 32'd8) begin bad++; $display("FAIL beq_imm got=%h exp=8", imm); end
        send(32'hFE20AE23, 32'h134);
        total++; if (imm !== 32'hFFFFFFFC) begin bad++; $display("FAIL sw_imm got=%h exp=fffffffc", imm); end
        total++; if ({op_class, reg_write, b_imm, funct3} !== {3'd2, 1'b0, 1'b1, 3'd2}) begin bad++;
            $display("FAIL sw_ctrl got=%0d/%0b/%0b/%0d exp=2/0/1/2", op_class, reg_write, b_imm, funct3); end
        send(32'h0000B083, 32'h138);
        total++; if ({illegal, op_class, reg_write} !== {1'b1, 3'd0, 1'b0}) begin bad++;
            $display("FAIL ld_illegal got=%0b/%0d/%0b exp=1/0/0", illegal, op_class, reg_write); end
        send(32'h010000EF, 32'h13C);
        total++; if ({op_class, a_sel, reg_write} !== {3'd4, 2'd1, 1'b1}) begin bad++;
            $display("FAIL jal_ctrl got=%0d/%0d/%0b exp=4/1/1", op_class, a_sel, reg_write); end
        total++; if (imm !== 32'd16) begin bad++; $display("FAIL jal_imm got=%h exp=10", imm); end
        send(32'h00000013, 32'h140);
        total++; if ({reg_write, illegal} !== 2'b00) begin bad++;
            $display("FAIL nop_rd0 got=%0b/%0b exp=0/0", reg_write, illegal); end
    endtask

    task automatic test_stall();
        idle();
        ex_ready = 1'b0;
        send(32'h00500093, 32'h200);
        in_valid = 1'b1;
        in_instr = 32'h00A00113;
        in_pc    = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
            total++; if ({ex_valid, ex_pc, imm, rd_addr} !== {1'b1, 32'h200, 32'd5, 5'd1}) begin bad++;
                $display("FAIL stall_hold cyc=%0d got=%0b/%h/%h/%0d exp=1/200/5/1", i, ex_valid, ex_pc, imm, rd_addr); end
            @(posedge clk);
        end
        #1;
        ex_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if ({ex_valid, ex_pc, imm, rd_addr} !== {1'b1, 32'h204, 32'd10, 5'd2}) begin bad++;
            $display("FAIL release_next got=%0b/%h/%h/%0d exp=1/204/a/2", ex_valid, ex_pc, imm, rd_addr); end
        @(posedge clk); #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL release_no_dup got=%0b exp=0", ex_valid); end
    endtask

    task automatic test_flush();
        idle();
        ex_ready = 1'b0;
        send(32'h00500093, 32'h200);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00A00113;
        in_pc    = 32'h204;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_ex_valid got=%0b exp=0", ex_valid); end
        ex_ready = 1'b1;
        send(32'h402081B3, 32'h300);
        total++; if ({ex_valid, alu_op, ex_pc} !== {1'b1, 4'd1, 32'h300}) begin bad++;
            $display("FAIL post_flush got=%0b/%0d/%h exp=1/1/300", ex_valid, alu_op, ex_pc); end
    endtask

    task automatic test_async_reset();
        idle();
        ex_ready = 1'b0;
        send(32'h402081B3, 32'h310);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL areset_ex_valid got=%0b exp=0", ex_valid); end
        total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL areset_alu_op got=%0d exp=0", alu_op); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready got=%0b exp=1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_lui_illegal();
        test_formats();
        test_stall();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
